// File: rtl/hack_pkg.sv
// Shared definitions for the Hack memory-mapped peripherals.
package hack_pkg;

    localparam int unsigned WORD_W = 16;

    typedef enum logic [1:0] {
        T_IDLE,
        T_RUN,
        T_DONE
    } timer_state_t;

endpackage

// File: rtl/countdown_timer_dec.sv
// Combinational decrementer, counterpart of the incrementer: out = in - 1 modulo 2^WIDTH.
module dec #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    localparam logic [WIDTH-1:0] ONE = 1;

    always_comb begin
        out = in - ONE;
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaler, sticky expiry flag, expiry strobe and optional auto-reload.
module countdown_timer
    import hack_pkg::*;
#(
    parameter int unsigned WIDTH      = WORD_W,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  auto_reload,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  expired_ack,
    output logic [WIDTH-1:0]      count,
    output logic                  running,
    output logic                  expired,
    output logic                  expire_pulse
);

    localparam logic [WIDTH-1:0]      CNT_ONE = 1;
    localparam logic [PRESCALE_W-1:0] PRE_ONE = 1;

    timer_state_t          state_q, state_d;
    logic [WIDTH-1:0]      count_q, count_d;
    logic [WIDTH-1:0]      reload_q, reload_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  expired_q, expired_d;
    logic                  pulse_q, pulse_d;
    logic [WIDTH-1:0]      count_dec;
    logic                  tick;

    dec #(.WIDTH(WIDTH)) u_dec (
        .in  (count_q),
        .out (count_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= T_IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            presc_q   <= '0;
            expired_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            presc_q   <= presc_d;
            expired_q <= expired_d;
            pulse_q   <= pulse_d;
        end
    end

    // >= rather than == so that lowering prescale below the running prescaler ticks at once
    assign tick = (state_q == T_RUN) && (presc_q >= prescale);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        presc_d  = '0;
        pulse_d  = 1'b0;

        if (stop) begin
            state_d = T_IDLE;
        end else if (load) begin
            count_d  = load_value;
            reload_d = load_value;
            // A zero load can never expire, so it must not be left counting.
            if (load_value == '0) begin
                state_d = (state_q == T_RUN) ? T_IDLE : state_q;
            end else if (state_q == T_RUN || start) begin
                state_d = T_RUN;
            end
        end else if (start && state_q != T_RUN) begin
            if (state_q == T_IDLE && count_q != '0) begin
                state_d = T_RUN;
            end else if (state_q == T_DONE && reload_q != '0) begin
                count_d = reload_q;
                state_d = T_RUN;
            end
        end else if (state_q == T_RUN) begin
            if (tick) begin
                if (count_q == CNT_ONE) begin
                    pulse_d = 1'b1;
                    if (auto_reload && reload_q != '0) begin
                        count_d = reload_q;
                    end else begin
                        count_d = '0;
                        state_d = T_DONE;
                    end
                end else begin
                    count_d = count_dec;
                end
            end else begin
                presc_d = presc_q + PRE_ONE;
            end
        end

        expired_d = pulse_d | (expired_q & ~expired_ack);
    end

    always_comb begin
        count        = count_q;
        running      = (state_q == T_RUN);
        expired      = expired_q;
        expire_pulse = pulse_q;
    end

endmodule
